// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two buffered producers share the register file's single write port.
// Round-robin drain into a registered write port, plus a pending-write mask and operand forwarding.
module regfile_wb_arbiter #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s0_valid,
    output logic            s0_ready,
    input  logic [4:0]      s0_rd,
    input  logic [XLEN-1:0] s0_data,
    input  logic            s1_valid,
    output logic            s1_ready,
    input  logic [4:0]      s1_rd,
    input  logic [XLEN-1:0] s1_data,
    output logic            wr_en,
    output logic [4:0]      wr_addr,
    output logic [XLEN-1:0] wr_data,
    output logic [31:0]     pend_mask,
    input  logic [4:0]      fwd_addr,
    output logic            fwd_hit,
    output logic [XLEN-1:0] fwd_data
);

    localparam int PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [1:0] non_empty;
    logic [1:0] push;
    logic [1:0] pop;
    entry_t     in_entry [2];

    entry_t mem_q [2][DEPTH];
    entry_t mem_d [2][DEPTH];
    ptr_t   rd_ptr_q [2];
    ptr_t   rd_ptr_d [2];
    ptr_t   wr_ptr_q [2];
    ptr_t   wr_ptr_d [2];
    cnt_t   count_q  [2];
    cnt_t   count_d  [2];

    logic            last_q, last_d;
    logic            grant_valid;
    logic            grant_src;
    entry_t          grant_entry;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    ptr_t            scan_idx;

    assign in_valid    = {s1_valid, s0_valid};
    assign in_entry[0] = {s0_rd, s0_data};
    assign in_entry[1] = {s1_rd, s1_data};
    assign s0_ready    = in_ready[0];
    assign s1_ready    = in_ready[1];
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;

    // A full FIFO refuses input even when it is draining this cycle.
    always_comb begin : fifo_status
        for (int s = 0; s < 2; s++) begin
            in_ready[s]  = rst && (count_q[s] != cnt_t'(DEPTH));
            non_empty[s] = (count_q[s] != '0);
        end
    end

    // Writes to x0 complete the handshake but are dropped here.
    always_comb begin : accept
        for (int s = 0; s < 2; s++) begin
            push[s] = in_valid[s] && in_ready[s] && (in_entry[s].rd != 5'd0);
        end
    end

    always_comb begin : arbitrate
        grant_valid = |non_empty;
        grant_src   = 1'b0;
        if (&non_empty) begin
            grant_src = ~last_q;
        end else if (non_empty[1]) begin
            grant_src = 1'b1;
        end
        pop = {grant_valid & grant_src, grant_valid & ~grant_src};
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin : next_state
        mem_d = mem_q;
        for (int s = 0; s < 2; s++) begin
            rd_ptr_d[s] = rd_ptr_q[s] + ptr_t'(pop[s]);
            wr_ptr_d[s] = wr_ptr_q[s] + ptr_t'(push[s]);
            count_d[s]  = count_q[s] + cnt_t'(push[s]) - cnt_t'(pop[s]);
            if (push[s]) begin
                mem_d[s][wr_ptr_q[s]] = in_entry[s];
            end
        end
        grant_entry = mem_q[grant_src][rd_ptr_q[grant_src]];
        wr_en_d     = grant_valid;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        last_d      = last_q;
        if (grant_valid) begin
            wr_addr_d = grant_entry.rd;
            wr_data_d = grant_entry.data;
            last_d    = grant_src;
        end
    end

    // NOTE: state flops use non-blocking assignment so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
            last_q    <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr_q[s] <= rd_ptr_d[s];
                wr_ptr_q[s] <= wr_ptr_d[s];
                count_q[s]  <= count_d[s];
            end
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // NOTE: FIFO storage has no reset; only slots below count_q are ever observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Scan from lowest to highest priority so the last match wins:
    // output register, then s0 oldest->youngest, then s1 oldest->youngest.
    always_comb begin : lookup
        pend_mask = '0;
        fwd_hit   = 1'b0;
        fwd_data  = '0;
        scan_idx  = '0;
        if (wr_en_q) begin
            pend_mask[wr_addr_q] = 1'b1;
            if (wr_addr_q == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = wr_data_q;
            end
        end
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                scan_idx = rd_ptr_q[s] + ptr_t'(i);
                if (cnt_t'(i) < count_q[s]) begin
                    pend_mask[mem_q[s][scan_idx].rd] = 1'b1;
                    if (mem_q[s][scan_idx].rd == fwd_addr) begin
                        fwd_hit  = 1'b1;
                        fwd_data = mem_q[s][scan_idx].data;
                    end
                end
            end
        end
        pend_mask[0] = 1'b0;
        if (fwd_addr == 5'd0) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table for isolated results, scoreboard of expected writes,
// and hand sequences for contention, backpressure, forwarding priority and mid-stream reset.
module tb_regfile_wb_arbiter;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    logic            clk;
    logic            rst;
    logic            s0_valid, s0_ready, s1_valid, s1_ready;
    logic [4:0]      s0_rd, s1_rd;
    logic [XLEN-1:0] s0_data, s1_data;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [31:0]     pend_mask;
    logic [4:0]      fwd_addr;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;

    regfile_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_rd    (s0_rd),
        .s0_data  (s0_data),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_rd    (s1_rd),
        .s1_data  (s1_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .pend_mask(pend_mask),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          src;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        bit          src;
        logic [4:0]  rd;
        logic [63:0] data;
        bit          exp_wr;
        logic [31:0] exp_pend;
        bit          exp_hit;
        logic [63:0] exp_fwd;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   occ [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit src, input bit v, input logic [4:0] rd, input logic [63:0] d);
        if (src) begin
            s1_valid = v; s1_rd = rd; s1_data = d;
        end else begin
            s0_valid = v; s0_rd = rd; s0_data = d;
        end
    endtask

    // Offer n consecutive results from one source; returns cycles spent.
    task automatic stream(input bit src, input logic [4:0] rd0, input int n,
                          input logic [63:0] d0, output int cycles);
        cycles = 0;
        for (int i = 0; i < n; i++) begin
            bit acc;
            acc = 1'b0;
            drive(src, 1'b1, 5'(rd0 + 5'(i)), d0 + 64'(i));
            while (!acc && cycles < 64) begin
                @(negedge clk);
                acc = src ? s1_ready : s0_ready;
                @(posedge clk); #1;
                cycles++;
            end
        end
        drive(src, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_en || pend_mask != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Write-port monitor plus an occupancy model used to predict ready.
    always @(negedge clk) begin
        if (!rst) begin
            occ[0] = 0;
            occ[1] = 0;
            check("s0_ready_in_reset", 64'(s0_ready), 64'd0);
            check("s1_ready_in_reset", 64'(s1_ready), 64'd0);
        end else begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write (t=%0t)",
                             wr_addr, wr_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(mon_e.rd));
                    check("wr_data", wr_data, mon_e.data);
                    if (occ[mon_e.src] > 0) occ[mon_e.src]--;
                end
            end
            check("s0_ready", 64'(s0_ready), 64'(occ[0] < DEPTH));
            check("s1_ready", 64'(s1_ready), 64'(occ[1] < DEPTH));
            if (s0_valid && s0_ready && s0_rd != 5'd0) occ[0]++;
            if (s1_valid && s1_ready && s1_rd != 5'd0) occ[1]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [6];
        vec_t        v;
        int          cyc, cyc0, cyc1;
        logic [4:0]  last_addr;
        logic [63:0] last_data;

        vecs[0] = '{1'b0, 5'd5,  64'hDEAD_BEEF,            1'b1, 32'h0000_0020, 1'b1, 64'hDEAD_BEEF};
        vecs[1] = '{1'b1, 5'd0,  64'h1234,                 1'b0, 32'h0000_0000, 1'b0, 64'h0};
        vecs[2] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 32'h8000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{1'b0, 5'd1,  64'h0,                    1'b1, 32'h0000_0002, 1'b1, 64'h0};
        vecs[4] = '{1'b0, 5'd0,  64'h5555,                 1'b0, 32'h0000_0000, 1'b0, 64'h0};
        vecs[5] = '{1'b1, 5'd17, 64'h8000_0000_0000_0001,  1'b1, 32'h0002_0000, 1'b1, 64'h8000_0000_0000_0001};
        last_addr = 5'd0;
        last_data = 64'd0;

        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 64'd0);
        drive(1'b1, 1'b0, 5'd0, 64'd0);
        fwd_addr = 5'd5;
        @(negedge clk);
        @(negedge clk);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_pend_mask", 64'(pend_mask), 64'd0);
        check("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        check("rst_fwd_data", fwd_data, 64'd0);
        #2 rst = 1'b1;

        // Isolated results: latency, pend_mask window, forwarding, x0 discard, write-port hold.
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            @(posedge clk); #1;
            fwd_addr = v.rd;
            drive(v.src, 1'b1, v.rd, v.data);
            if (v.exp_wr) exp_q.push_back('{v.src, v.rd, v.data});
            @(negedge clk);
            check($sformatf("v%0d_ready", i), 64'(v.src ? s1_ready : s0_ready), 64'd1);
            @(posedge clk); #1;
            drive(v.src, 1'b0, 5'd0, 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_accept_wr_en", i), 64'(wr_en), 64'd0);
            check($sformatf("v%0d_accept_pend", i), 64'(pend_mask), 64'(v.exp_pend));
            check($sformatf("v%0d_accept_fwd_hit", i), 64'(fwd_hit), 64'(v.exp_hit));
            check($sformatf("v%0d_accept_fwd_data", i), fwd_data, v.exp_fwd);
            @(negedge clk);
            check($sformatf("v%0d_write_wr_en", i), 64'(wr_en), 64'(v.exp_wr));
            check($sformatf("v%0d_write_pend", i), 64'(pend_mask), 64'(v.exp_pend));
            check($sformatf("v%0d_write_fwd_data", i), fwd_data, v.exp_fwd);
            if (v.exp_wr) begin
                last_addr = v.rd;
                last_data = v.data;
            end
            @(negedge clk);
            check($sformatf("v%0d_after_wr_en", i), 64'(wr_en), 64'd0);
            check($sformatf("v%0d_after_pend", i), 64'(pend_mask), 64'd0);
            check($sformatf("v%0d_after_fwd_hit", i), 64'(fwd_hit), 64'd0);
            check($sformatf("v%0d_hold_addr", i), 64'(wr_addr), 64'(last_addr));
            check($sformatf("v%0d_hold_data", i), wr_data, last_data);
        end
        wait_idle("table_drain");

        // Contention: last grant was s1, so s0 wins the first tie and writes alternate.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{1'b0, 5'(1 + i),  64'h1000 + 64'(i)});
            exp_q.push_back('{1'b1, 5'(11 + i), 64'h2000 + 64'(i)});
        end
        @(posedge clk); #1;
        fork
            stream(1'b0, 5'd1,  4, 64'h1000, cyc0);
            stream(1'b1, 5'd11, 4, 64'h2000, cyc1);
        join
        check("contention_s0_bounded", 64'(cyc0 < 64), 64'd1);
        check("contention_s1_bounded", 64'(cyc1 < 64), 64'd1);
        wait_idle("contention_drain");

        // Single source back to back: one drain per cycle keeps s0_ready high.
        for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, 5'(20 + i), 64'h300 + 64'(i)});
        @(posedge clk); #1;
        stream(1'b0, 5'd20, 3, 64'h300, cyc);
        check("s0_alone_cycles", 64'(cyc), 64'd3);
        wait_idle("s0_alone_drain");

        // Both sources for DEPTH+2 results; last grant was s0, so s1 leads.
        for (int i = 0; i < DEPTH + 2; i++) begin
            exp_q.push_back('{1'b1, 5'(24 + i), 64'h400 + 64'(i)});
            exp_q.push_back('{1'b0, 5'(28 + i), 64'h500 + 64'(i)});
        end
        @(posedge clk); #1;
        fork
            stream(1'b0, 5'd28, DEPTH + 2, 64'h500, cyc0);
            stream(1'b1, 5'd24, DEPTH + 2, 64'h400, cyc1);
        join
        check("backpressure_s0_bounded", 64'(cyc0 < 64), 64'd1);
        check("backpressure_s1_bounded", 64'(cyc1 < 64), 64'd1);
        wait_idle("backpressure_drain");

        // Forwarding returns the youngest value for a register.
        @(posedge clk); #1;
        fwd_addr = 5'd7;
        drive(1'b0, 1'b1, 5'd7, 64'hA);
        exp_q.push_back('{1'b0, 5'd7, 64'hA});
        @(negedge clk);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 5'd7, 64'hB);
        exp_q.push_back('{1'b0, 5'd7, 64'hB});
        @(negedge clk);
        check("fwd_only_a_hit", 64'(fwd_hit), 64'd1);
        check("fwd_only_a_data", fwd_data, 64'hA);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'd0, 64'd0);
        @(negedge clk);
        check("fwd_b_in_fifo_data", fwd_data, 64'hB);
        @(negedge clk);
        check("fwd_b_in_outreg_data", fwd_data, 64'hB);
        @(negedge clk);
        check("fwd_gone_hit", 64'(fwd_hit), 64'd0);
        check("fwd_gone_data", fwd_data, 64'd0);
        wait_idle("fwd_drain");

        // Same rd from both sources: s1 FIFO beats s0 FIFO beats the output register.
        @(posedge clk); #1;
        fwd_addr = 5'd9;
        drive(1'b0, 1'b1, 5'd9, 64'hC0DE);
        drive(1'b1, 1'b1, 5'd9, 64'hFACE);
        exp_q.push_back('{1'b1, 5'd9, 64'hFACE});
        exp_q.push_back('{1'b0, 5'd9, 64'hC0DE});
        @(negedge clk);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'd0, 64'd0);
        drive(1'b1, 1'b0, 5'd0, 64'd0);
        @(negedge clk);
        check("prio_both_fifos_data", fwd_data, 64'hFACE);
        check("prio_both_fifos_pend", 64'(pend_mask), 64'h200);
        @(negedge clk);
        check("prio_s0_over_outreg", fwd_data, 64'hC0DE);
        @(negedge clk);
        check("prio_outreg_data", fwd_data, 64'hC0DE);
        wait_idle("prio_drain");

        // Mid-stream reset with one result in the output register and one in the FIFO.
        @(posedge clk); #1;
        fwd_addr = 5'd4;
        drive(1'b0, 1'b1, 5'd3, 64'hC3);
        exp_q.push_back('{1'b0, 5'd3, 64'hC3});
        @(negedge clk);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 5'd4, 64'hC4);
        @(negedge clk);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'd0, 64'd0);
        @(negedge clk);
        check("pre_reset_wr_en", 64'(wr_en), 64'd1);
        check("pre_reset_pend", 64'(pend_mask), 64'h18);
        check("pre_reset_fwd_data", fwd_data, 64'hC4);
        #2 rst = 1'b0;
        #1;
        check("async_reset_wr_en", 64'(wr_en), 64'd0);
        check("async_reset_pend", 64'(pend_mask), 64'd0);
        check("async_reset_fwd_hit", 64'(fwd_hit), 64'd0);
        check("async_reset_wr_data", wr_data, 64'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_wr_en_%0d", i), 64'(wr_en), 64'd0);
        end
        check("post_reset_pend", 64'(pend_mask), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
